letter_tx_queue: RTL and testbench

- Parametrised transmit queue between a character producer (enigma encoder output) and a busy-handshaked serial consumer (IR transmitter).
- Replaces the fixed 1000×5 letter buffer and its ad-hoc pointer logic with one self-contained block.
- Adds configurable width and depth (non-power-of-two depth allowed), full/empty/count status, a selectable overflow policy, flush, and a consumer-stall timeout.

---
 rtl/letter_tx_queue.sv | 131 +++++++++++++
 tb/tb_letter_tx_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/letter_tx_queue.sv
// Transmit queue between the letter encoder and a busy-handshaked serial transmitter.
// Circular buffer of arbitrary depth with registered read, overflow policy, flush and busy timeout.
module letter_tx_queue #(
    parameter int unsigned WIDTH        = 5,
    parameter int unsigned DEPTH        = 1000,
    parameter int unsigned OVERWRITE    = 0,
    parameter int unsigned BUSY_TIMEOUT = 1000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush_in,
    input  logic                       data_valid_in,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       tx_busy_in,
    output logic                       tx_valid_out,
    output logic [WIDTH-1:0]           tx_data_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       overflow_out,
    output logic                       timeout_out
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state_q, state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] count_next;
    logic             pop_c, push_c, overwrite_c, drop_c, timeout_c, can_overwrite_c;

    // Pointer increment with wrap at DEPTH-1 (depth need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state, pop/push/overwrite decisions and next occupancy
    always_comb begin
        state_next      = state_q;
        timeout_c       = 1'b0;
        pop_c           = 1'b0;
        push_c          = 1'b0;
        overwrite_c     = 1'b0;
        drop_c          = 1'b0;
        can_overwrite_c = 1'b0;
        count_next      = count_out;

        unique case (state_q)
            IDLE:      if (count_out != '0) state_next = FETCH;
            FETCH:     state_next = ISSUE;
            ISSUE: begin
                pop_c      = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_in) begin
                    state_next = WAIT_DONE;
                end else if (timer_q >= TMR_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_c  = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: if (!tx_busy_in) state_next = IDLE;
            default:   state_next = IDLE;
        endcase

        // Overwriting is barred while an entry is being fetched or issued
        can_overwrite_c = (OVERWRITE != 0) &&
                          (state_q == IDLE || state_q == WAIT_BUSY || state_q == WAIT_DONE);

        if (data_valid_in) begin
            if (!full_out || pop_c) push_c = 1'b1;
            else if (can_overwrite_c) overwrite_c = 1'b1;
            else drop_c = 1'b1;
        end

        if (push_c && !pop_c) count_next = count_out + CNT_W'(1);
        else if (!push_c && pop_c) count_next = count_out - CNT_W'(1);
    end

    // State, pointers, status and issue registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            timer_q      <= '0;
            count_out    <= '0;
            full_out     <= 1'b0;
            empty_out    <= 1'b1;
            tx_valid_out <= 1'b0;
            tx_data_out  <= '0;
            overflow_out <= 1'b0;
            timeout_out  <= 1'b0;
        end else if (flush_in) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            timer_q      <= '0;
            count_out    <= '0;
            full_out     <= 1'b0;
            empty_out    <= 1'b1;
            tx_valid_out <= 1'b0;
            overflow_out <= 1'b0;
            timeout_out  <= 1'b0;
        end else begin
            state_q <= state_next;
            if (push_c || overwrite_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_c || overwrite_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            // Timer counts from the issue cycle
            timer_q      <= (state_q == ISSUE || state_q == WAIT_BUSY) ? timer_q + TMR_W'(1) : '0;
            count_out    <= count_next;
            full_out     <= (count_next == CNT_W'(DEPTH));
            empty_out    <= (count_next == '0);
            tx_valid_out <= (state_q == FETCH);
            if (state_q == FETCH) tx_data_out <= mem[rd_ptr_q];
            if (drop_c || overwrite_c) overflow_out <= 1'b1;
            timeout_out  <= timeout_c;
        end
    end

    // Storage array, no reset so it can map onto block RAM
    always_ff @(posedge clk_in) begin
        if ((push_c || overwrite_c) && !flush_in) mem[wr_ptr_q] <= data_in;
    end

endmodule

// File: tb/tb_letter_tx_queue.sv
// Directed bench for letter_tx_queue: four instances covering ordering, drop, overwrite,
// pointer wrap with simultaneous push/pop, busy timeout, flush and asynchronous reset.
module tb_letter_tx_queue;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      flush, dv, busy;
    logic [3:0][4:0] din;
    logic [3:0]      txv, full, empty, ovf, tmo;
    logic [3:0][4:0] txd;
    logic [3:0]      c0;
    logic [2:0]      c1, c2, c3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // i0: DEPTH 8 drop policy, timeout 16
    letter_tx_queue #(.WIDTH(5), .DEPTH(8), .OVERWRITE(0), .BUSY_TIMEOUT(16)) u_q0 (
        .clk_in(clk), .rst_in(rst_n), .flush_in(flush[0]), .data_valid_in(dv[0]),
        .data_in(din[0]), .tx_busy_in(busy[0]), .tx_valid_out(txv[0]), .tx_data_out(txd[0]),
        .full_out(full[0]), .empty_out(empty[0]), .count_out(c0), .overflow_out(ovf[0]),
        .timeout_out(tmo[0]));
    // i1: DEPTH 4 drop policy
    letter_tx_queue #(.WIDTH(5), .DEPTH(4), .OVERWRITE(0), .BUSY_TIMEOUT(1000)) u_q1 (
        .clk_in(clk), .rst_in(rst_n), .flush_in(flush[1]), .data_valid_in(dv[1]),
        .data_in(din[1]), .tx_busy_in(busy[1]), .tx_valid_out(txv[1]), .tx_data_out(txd[1]),
        .full_out(full[1]), .empty_out(empty[1]), .count_out(c1), .overflow_out(ovf[1]),
        .timeout_out(tmo[1]));
    // i2: DEPTH 4 overwrite policy
    letter_tx_queue #(.WIDTH(5), .DEPTH(4), .OVERWRITE(1), .BUSY_TIMEOUT(1000)) u_q2 (
        .clk_in(clk), .rst_in(rst_n), .flush_in(flush[2]), .data_valid_in(dv[2]),
        .data_in(din[2]), .tx_busy_in(busy[2]), .tx_valid_out(txv[2]), .tx_data_out(txd[2]),
        .full_out(full[2]), .empty_out(empty[2]), .count_out(c2), .overflow_out(ovf[2]),
        .timeout_out(tmo[2]));
    // i3: DEPTH 5 (non power of two) drop policy
    letter_tx_queue #(.WIDTH(5), .DEPTH(5), .OVERWRITE(0), .BUSY_TIMEOUT(1000)) u_q3 (
        .clk_in(clk), .rst_in(rst_n), .flush_in(flush[3]), .data_valid_in(dv[3]),
        .data_in(din[3]), .tx_busy_in(busy[3]), .tx_valid_out(txv[3]), .tx_data_out(txd[3]),
        .full_out(full[3]), .empty_out(empty[3]), .count_out(c3), .overflow_out(ovf[3]),
        .timeout_out(tmo[3]));

    typedef struct {
        int         n;
        logic       dv;
        logic [4:0] d;
        logic       busy;
        logic       ev;
        logic [4:0] ed;
        int         ec;
        logic       ee;
    } vec_t;

    vec_t tbl [17];

    function automatic int cnt(input int i);
        case (i)
            0:       return int'(c0);
            1:       return int'(c1);
            2:       return int'(c2);
            default: return int'(c3);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for an issue pulse on instance i
    task automatic wait_valid(input int i, input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (txv[i]) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, int'(ok), 1);
    endtask

    initial begin
        bit seen;
        int exp_drop [4] = '{1, 2, 3, 4};
        int exp_ovw  [4] = '{3, 4, 5, 6};

        tbl[0]  = '{1,  1'b1, 5'd3,  1'b0, 1'b0, 5'd0,  1, 1'b0};
        tbl[1]  = '{1,  1'b1, 5'd7,  1'b0, 1'b0, 5'd0,  2, 1'b0};
        tbl[2]  = '{1,  1'b1, 5'd19, 1'b0, 1'b1, 5'd3,  3, 1'b0};
        tbl[3]  = '{1,  1'b0, 5'd0,  1'b0, 1'b0, 5'd3,  2, 1'b0};
        tbl[4]  = '{1,  1'b0, 5'd0,  1'b0, 1'b0, 5'd3,  2, 1'b0};
        tbl[5]  = '{10, 1'b0, 5'd0,  1'b1, 1'b0, 5'd3,  2, 1'b0};
        tbl[6]  = '{2,  1'b0, 5'd0,  1'b0, 1'b0, 5'd3,  2, 1'b0};
        tbl[7]  = '{1,  1'b0, 5'd0,  1'b0, 1'b1, 5'd7,  2, 1'b0};
        tbl[8]  = '{1,  1'b0, 5'd0,  1'b0, 1'b0, 5'd7,  1, 1'b0};
        tbl[9]  = '{1,  1'b0, 5'd0,  1'b0, 1'b0, 5'd7,  1, 1'b0};
        tbl[10] = '{10, 1'b0, 5'd0,  1'b1, 1'b0, 5'd7,  1, 1'b0};
        tbl[11] = '{2,  1'b0, 5'd0,  1'b0, 1'b0, 5'd7,  1, 1'b0};
        tbl[12] = '{1,  1'b0, 5'd0,  1'b0, 1'b1, 5'd19, 1, 1'b0};
        tbl[13] = '{1,  1'b0, 5'd0,  1'b0, 1'b0, 5'd19, 0, 1'b1};
        tbl[14] = '{1,  1'b0, 5'd0,  1'b0, 1'b0, 5'd19, 0, 1'b1};
        tbl[15] = '{10, 1'b0, 5'd0,  1'b1, 1'b0, 5'd19, 0, 1'b1};
        tbl[16] = '{5,  1'b0, 5'd0,  1'b0, 1'b0, 5'd19, 0, 1'b1};

        rst_n = 1'b0;
        flush = '0;
        dv    = '0;
        din   = '0;
        busy  = 4'b1110;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_valid[%0d]", i), int'(txv[i]), 0);
            check($sformatf("reset_data[%0d]", i), int'(txd[i]), 0);
            check($sformatf("reset_count[%0d]", i), cnt(i), 0);
            check($sformatf("reset_empty[%0d]", i), int'(empty[i]), 1);
            check($sformatf("reset_full[%0d]", i), int'(full[i]), 0);
            check($sformatf("reset_ovf[%0d]", i), int'(ovf[i]), 0);
            check($sformatf("reset_tmo[%0d]", i), int'(tmo[i]), 0);
        end
        rst_n = 1'b1;

        // Basic ordering and issue spacing on i0, cycle-exact
        for (int r = 0; r < 17; r++) begin
            dv[0]   = tbl[r].dv;
            din[0]  = tbl[r].d;
            busy[0] = tbl[r].busy;
            for (int k = 0; k < tbl[r].n; k++) tick();
            check($sformatf("tbl%0d_valid", r), int'(txv[0]), int'(tbl[r].ev));
            check($sformatf("tbl%0d_data", r), int'(txd[0]), int'(tbl[r].ed));
            check($sformatf("tbl%0d_count", r), cnt(0), tbl[r].ec);
            check($sformatf("tbl%0d_empty", r), int'(empty[0]), int'(tbl[r].ee));
            check($sformatf("tbl%0d_full", r), int'(full[0]), 0);
            check($sformatf("tbl%0d_tmo", r), int'(tmo[0]), 0);
        end
        dv[0] = 1'b0;

        // Timeout on i0: busy stays low, pulse 16 cycles after the issue cycle
        dv[0] = 1'b1; din[0] = 5'd9;
        tick();
        dv[0] = 1'b0;
        wait_valid(0, "timeout_issue_seen");
        check("timeout_issue_data", int'(txd[0]), 9);
        seen = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (tmo[0]) seen = 1'b1;
        end
        check("timeout_early", int'(seen), 0);
        tick();
        check("timeout_pulse", int'(tmo[0]), 1);
        check("timeout_count", cnt(0), 0);
        check("timeout_empty", int'(empty[0]), 1);
        tick();
        check("timeout_one_cycle", int'(tmo[0]), 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (txv[0]) seen = 1'b1;
        end
        check("timeout_no_retry", int'(seen), 0);

        // Drop (i1) and overwrite (i2): park the FSM in WAIT_DONE on a dummy entry
        dv[2:1] = 2'b11; din[1] = 5'd0; din[2] = 5'd0;
        tick();
        dv[2:1] = 2'b00;
        wait_valid(1, "dummy_issue_seen");
        check("dummy_issue_i2", int'(txv[2]), 1);
        tick();
        tick();
        for (int v = 1; v <= 6; v++) begin
            dv[2:1] = 2'b11; din[1] = 5'(v); din[2] = 5'(v);
            tick();
        end
        dv[2:1] = 2'b00;
        check("drop_count", cnt(1), 4);
        check("drop_full", int'(full[1]), 1);
        check("drop_ovf", int'(ovf[1]), 1);
        check("ovw_count", cnt(2), 4);
        check("ovw_full", int'(full[2]), 1);
        check("ovw_ovf", int'(ovf[2]), 1);
        for (int e = 0; e < 4; e++) begin
            busy[2:1] = 2'b00;
            wait_valid(1, $sformatf("drain%0d_seen", e));
            check($sformatf("drain%0d_drop_data", e), int'(txd[1]), exp_drop[e]);
            check($sformatf("drain%0d_ovw_valid", e), int'(txv[2]), 1);
            check($sformatf("drain%0d_ovw_data", e), int'(txd[2]), exp_ovw[e]);
            busy[2:1] = 2'b11;
            tick();
            tick();
        end
        check("drain_empty_i1", int'(empty[1]), 1);
        check("drain_empty_i2", int'(empty[2]), 1);

        // Flush with three entries queued and overflow still set
        for (int v = 7; v <= 9; v++) begin
            dv[2:1] = 2'b11; din[1] = 5'(v); din[2] = 5'(v);
            tick();
        end
        dv[2:1] = 2'b00;
        check("preflush_count", cnt(1), 3);
        check("preflush_ovf", int'(ovf[1]), 1);
        flush[2:1] = 2'b11;
        tick();
        flush[2:1] = 2'b00;
        check("flush_count", cnt(1), 0);
        check("flush_empty", int'(empty[1]), 1);
        check("flush_ovf", int'(ovf[1]), 0);
        check("flush_ovf_i2", int'(ovf[2]), 0);
        check("flush_data_hold", int'(txd[1]), 4);
        check("flush_data_hold_i2", int'(txd[2]), 6);
        busy[2:1] = 2'b00;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (txv[1] || txv[2]) seen = 1'b1;
        end
        check("flush_no_issue", int'(seen), 0);

        // Wrap on i3: full queue, a write lands on every issue cycle
        dv[3] = 1'b1; din[3] = 5'd0;
        tick();
        dv[3] = 1'b0;
        wait_valid(3, "wrap_dummy_seen");
        tick();
        tick();
        for (int v = 1; v <= 5; v++) begin
            dv[3] = 1'b1; din[3] = 5'(v);
            tick();
        end
        dv[3] = 1'b0;
        check("wrap_prefill_count", cnt(3), 5);
        check("wrap_prefill_full", int'(full[3]), 1);
        for (int j = 0; j < 12; j++) begin
            busy[3] = 1'b0;
            wait_valid(3, $sformatf("wrap%0d_seen", j));
            check($sformatf("wrap%0d_data", j), int'(txd[3]), j + 1);
            dv[3] = 1'b1; din[3] = 5'(6 + j); busy[3] = 1'b1;
            tick();
            dv[3] = 1'b0;
            check($sformatf("wrap%0d_count", j), cnt(3), 5);
            check($sformatf("wrap%0d_ovf", j), int'(ovf[3]), 0);
            tick();
        end

        // Asynchronous reset while i0 sits in WAIT_DONE
        busy[0] = 1'b1;
        dv[0] = 1'b1; din[0] = 5'd21;
        tick();
        din[0] = 5'd22;
        tick();
        dv[0] = 1'b0;
        wait_valid(0, "prereset_issue_seen");
        check("prereset_data", int'(txd[0]), 21);
        tick();
        tick();
        check("prereset_count", cnt(0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", int'(txd[0]), 0);
        check("async_rst_count", cnt(0), 0);
        check("async_rst_empty", int'(empty[0]), 1);
        check("async_rst_full3", int'(full[3]), 0);
        check("async_rst_count3", cnt(3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
